qlf_frac_lut_cluster: RTL and testbench



---
 rtl/qlf_cluster_pkg.sv | 17 +
 rtl/qlf_ble.sv | 54 +++++
 rtl/qlf_frac_lut_cluster.sv | 122 ++++++++++++
 tb/tb_qlf_frac_lut_cluster.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/qlf_cluster_pkg.sv
// Shared constants for the fracturable LUT4 cluster: per-BLE config word layout
// and the scan-load FSM state encoding.
package qlf_cluster_pkg;

  localparam int CFG_W   = 19;
  localparam int LUT_LSB = 0;
  localparam int CIN_SEL = 16;
  localparam int FF_EN   = 17;
  localparam int FF_INIT = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    READY = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/qlf_ble.sv
// One basic logic element: LUT4 mux tree with optional carry-in on li[2],
// carry mux into the next BLE, and an optional output flop.
module qlf_ble
  import qlf_cluster_pkg::*;
(
  input  logic             C,
  input  logic             R,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic [3:0]       li_i,
  input  logic             cin_i,
  input  logic             commit_i,
  output logic             out_o,
  output logic             cout_o
);

  logic [15:0] lut;
  logic [3:0]  li;
  logic [7:0]  s1;
  logic [3:0]  s2;
  logic [1:0]  s3;
  logic        lut_out;
  logic        q_q, q_d;
  logic        pend_q, pend_d;

  assign lut = cfg_i[LUT_LSB +: 16];
  assign li  = {li_i[3], (cfg_i[CIN_SEL] ? cin_i : li_i[2]), li_i[1:0]};

  always_comb begin
    for (int j = 0; j < 8; j++) s1[j] = li[0] ? lut[2*j+1] : lut[2*j];
    for (int j = 0; j < 4; j++) s2[j] = li[1] ? s1[2*j+1] : s1[2*j];
    for (int j = 0; j < 2; j++) s3[j] = li[2] ? s2[2*j+1] : s2[2*j];
    lut_out = li[3] ? s3[1] : s3[0];
  end

  assign cout_o = s2[2] ? cin_i : s2[3];

  // The committed word only reaches cfg_i at the commit edge, so for the cycle
  // after a commit the flop value is FF_INIT taken from the now-active word.
  assign q_d    = lut_out;
  assign pend_d = commit_i;

  always_ff @(posedge C) begin
    if (!R) begin
      q_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pend_q <= pend_d;
    end
  end

  assign out_o = cfg_i[FF_EN] ? (pend_q ? cfg_i[FF_INIT] : q_q) : lut_out;

endmodule

// File: rtl/qlf_frac_lut_cluster.sv
// Cluster of N_BLE fracturable LUT4 BLEs with a serial shadow/active config chain.
// Define QLF_CLUSTER_CFG_READBACK_EN to expose the shadow chain tail on cfg_dout.
module qlf_frac_lut_cluster
  import qlf_cluster_pkg::*;
#(
  parameter int N_BLE = 8
) (
  input  logic               C,
  input  logic               R,
  input  logic               cfg_en,
  input  logic               cfg_din,
  input  logic               cfg_commit,
  output logic               cfg_dout,
  output logic               cfg_done,
  output logic               cfg_err,
  input  logic [4*N_BLE-1:0] in,
  input  logic               cin,
  output logic [N_BLE-1:0]   out,
  output logic               cout
);

  localparam int TOT   = N_BLE * CFG_W;
  localparam int CNT_W = $clog2(TOT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOT);

  cfg_state_e       state_q, state_d;
  logic [TOT-1:0]   sh_q, sh_d;
  logic [TOT-1:0]   act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             do_shift, do_commit, bad_commit;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= IDLE;
      sh_q    <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // A commit always takes priority over a shift in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_en && !cfg_commit) state_d = (cnt_inc == CNT_MAX) ? READY : SHIFT;
      SHIFT:   if (cfg_en && !cfg_commit && cnt_inc == CNT_MAX) state_d = READY;
      READY:   if (cfg_commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_shift   = cfg_en && !cfg_commit;
    do_commit  = cfg_commit && (state_q == READY);
    bad_commit = cfg_commit && (state_q != READY);
  end

  always_comb begin
    sh_d   = sh_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    err_d  = err_q;
    if (do_shift) begin
      sh_d  = {cfg_din, sh_q[TOT-1:1]};
      cnt_d = cnt_inc;
    end
    if (do_commit) begin
      act_d  = sh_q;
      cnt_d  = '0;
      done_d = 1'b1;
    end
    if (bad_commit) err_d = 1'b1;
  end

  assign cfg_done = done_q;
  assign cfg_err  = err_q;

`ifdef QLF_CLUSTER_CFG_READBACK_EN
  assign cfg_dout = sh_q[0];
`else
  assign cfg_dout = 1'b0;
`endif

  for (genvar i = 0; i < N_BLE; i++) begin : g_ble
    logic ci, co, bo;
    if (i == 0) begin : g_head
      assign ci = cin;
    end else begin : g_link
      assign ci = g_ble[i-1].co;
    end

    qlf_ble u_ble (
      .C        (C),
      .R        (R),
      .cfg_i    (act_q[CFG_W*i +: CFG_W]),
      .li_i     (in[4*i +: 4]),
      .cin_i    (ci),
      .commit_i (do_commit),
      .out_o    (bo),
      .cout_o   (co)
    );

    assign out[i] = bo;
  end

  assign cout = g_ble[N_BLE-1].co;

endmodule

// File: tb/tb_qlf_frac_lut_cluster.sv
// Scoreboard bench for qlf_frac_lut_cluster: directed loads, LUT/carry/flop checks.
module tb_qlf_frac_lut_cluster;

  localparam int NB  = 8;
  localparam int TOT = NB * 19;
`ifdef QLF_CLUSTER_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic C = 1'b0;
  logic R, cfg_en, cfg_din, cfg_commit, cin;
  logic cfg_dout, cfg_done, cfg_err, cout;
  logic [4*NB-1:0] in;
  logic [NB-1:0]   out;
  logic            smp;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string         nm;
    logic [NB-1:0] o;
    logic [NB-1:0] om;
    logic          co;
    bit            cc;
    logic          dn;
    logic          er;
    logic          dv;
    bit            dc;
  } exp_t;

  exp_t sbq[$];

  always #5 C = ~C;

  qlf_frac_lut_cluster #(.N_BLE(NB)) dut (
    .C          (C),
    .R          (R),
    .cfg_en     (cfg_en),
    .cfg_din    (cfg_din),
    .cfg_commit (cfg_commit),
    .cfg_dout   (cfg_dout),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .in         (in),
    .cin        (cin),
    .out        (out),
    .cout       (cout)
  );

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp_v);
  endtask

  always @(negedge C) begin : mon
    exp_t e;
    if (smp) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_underflow", 8'd1, 8'd0);
      end else begin
        e = sbq.pop_front();
        if (e.om != '0) chk({e.nm, ".out"}, out & e.om, e.o & e.om);
        if (e.cc) chk({e.nm, ".cout"}, {7'd0, cout}, {7'd0, e.co});
        chk({e.nm, ".cfg_done"}, {7'd0, cfg_done}, {7'd0, e.dn});
        chk({e.nm, ".cfg_err"}, {7'd0, cfg_err}, {7'd0, e.er});
        if (e.dc || !RB) chk({e.nm, ".cfg_dout"}, {7'd0, cfg_dout}, {7'd0, e.dv});
      end
    end
  end

  task automatic exp_push(input string nm, input logic [NB-1:0] o, input logic [NB-1:0] om,
                          input logic co, input bit cc, input logic dn, input logic er,
                          input logic dv = 1'b0, input bit dc = 1'b0);
    exp_t e;
    e.nm = nm; e.o = o; e.om = om; e.co = co; e.cc = cc;
    e.dn = dn; e.er = er; e.dv = dv; e.dc = dc;
    sbq.push_back(e);
    smp = 1'b1;
  endtask

  task automatic tick();
    @(posedge C);
    #1;
    smp = 1'b0;
  endtask

  function automatic logic [TOT-1:0] mkw(input logic [15:0] lut, input logic cs,
                                         input logic fe, input logic fi);
    logic [TOT-1:0] w;
    for (int i = 0; i < NB; i++) w[19*i +: 19] = {fi, fe, cs, lut};
    return w;
  endfunction

  // Each bit set here is taken by the following clock edge.
  task automatic shift_bits(input logic [TOT-1:0] w, input int lo, input int n);
    for (int k = lo; k < lo + n; k++) begin
      tick();
      cfg_en  = 1'b1;
      cfg_din = w[k];
    end
  endtask

  task automatic do_commit();
    tick();
    cfg_en     = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [TOT-1:0] w_xor, w_add, w_ff;
    w_xor = mkw(16'h6996, 1'b0, 1'b0, 1'b0);
    w_add = mkw(16'h9696, 1'b1, 1'b0, 1'b0);
    w_ff  = mkw(16'h6996, 1'b0, 1'b1, 1'b1);

    R = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    in = '1; cin = 1'b1; smp = 1'b0;
    tick();
    tick();
    exp_push("reset", 8'h00, 8'hFF, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1);
    tick();
    R = 1'b1;

    shift_bits(w_xor, 0, TOT);
    do_commit();
    in = 32'h7777_7777; cin = 1'b1;
    exp_push("xor_ones", 8'hFF, 8'hFF, 1'b1, 1, 1'b1, 1'b0);
    tick(); in = '0; cin = 1'b0;
    exp_push("xor_zero", 8'h00, 8'hFF, 1'b0, 1, 1'b1, 1'b0);
    tick(); in = 32'h0123_4567;
    exp_push("xor_mix", 8'h69, 8'hFF, 1'b1, 1, 1'b1, 1'b0);
    tick(); in = '0; cin = 1'b1;
    exp_push("xor_prop", 8'h00, 8'hFF, 1'b1, 1, 1'b1, 1'b0);

    shift_bits(w_add, 0, 100);
    do_commit();
    in = 32'h7777_7777; cin = 1'b0;
    exp_push("early_commit", 8'hFF, 8'hFF, 1'b0, 1, 1'b1, 1'b1);
    shift_bits(w_add, 100, TOT - 100);
    do_commit();
    in = 32'h1111_1113; cin = 1'b0;
    exp_push("add_ff_01", 8'h00, 8'hFF, 1'b1, 1, 1'b1, 1'b1);
    tick(); in = 32'h2121_2121; cin = 1'b1;
    exp_push("add_55_aa_c1", 8'h00, 8'hFF, 1'b1, 1, 1'b1, 1'b1);
    tick(); cin = 1'b0;
    exp_push("add_55_aa_c0", 8'hFF, 8'hFF, 1'b0, 1, 1'b1, 1'b1);

    shift_bits(w_ff, 0, TOT);
    tick();
    cfg_din = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    in = 32'h0123_4567; cin = 1'b0;
    exp_push("ff_init", 8'hFF, 8'hFF, 1'b1, 1, 1'b1, 1'b1);
    tick(); in = '0;
    exp_push("ff_delay1", 8'h69, 8'hFF, 1'b0, 1, 1'b1, 1'b1);
    tick(); in = 32'h7777_7777;
    exp_push("ff_delay2", 8'h00, 8'hFF, 1'b0, 1, 1'b1, 1'b1);
    tick(); cin = 1'b1;
    exp_push("ff_delay3", 8'hFF, 8'hFF, 1'b1, 1, 1'b1, 1'b1);

    tick();
    for (int k = 0; k < 24; k++) begin
      tick();
      cfg_en = 1'b1; cfg_din = 1'b0;
      exp_push($sformatf("readback%0d", k), 8'h00, 8'h00, 1'b0, 0, 1'b1, 1'b1,
               RB ? w_ff[k] : 1'b0, 1);
    end
    tick();
    cfg_en = 1'b0;

    shift_bits(w_xor, 0, 50);
    tick();
    cfg_en = 1'b0; R = 1'b0;
    tick();
    R = 1'b1; in = 32'h7777_7777; cin = 1'b1;
    exp_push("mid_reset", 8'h00, 8'hFF, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1);
    shift_bits(w_xor, 0, TOT - 1);
    do_commit();
    exp_push("short_commit", 8'h00, 8'hFF, 1'b0, 1, 1'b0, 1'b1);
    shift_bits(w_xor, TOT - 1, 1);
    do_commit();
    exp_push("reload", 8'hFF, 8'hFF, 1'b1, 1, 1'b1, 1'b1);

    tick();
    tick();
    chk("scoreboard_drained", NB'(sbq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
